stage1: RTL and testbench
=========================

STAGE1 -- requirements
Module: stage1

Interface
REQ-001 SHALL have parameter RESET_PC, default 48'h0, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, instr value presented with a fetch trap.
REQ-003 SHALL have ports: clk  in  1  sole clock; n_reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  48  word-aligned fetch address; imem_gnt  in  1  request accepted.
REQ-005 SHALL have ports: imem_rvalid  in  1  response valid; imem_rdata  in  32  fetched word; imem_err  in  1  access fault with response.
REQ-006 SHALL have ports: redirect_valid  in  1  branch/trap redirect; redirect_pc  in  48  new fetch target.
REQ-007 SHALL have ports: stall_dec  in  1  decode cannot accept; valid_if  out  1  pc/instr valid to decode.
REQ-008 SHALL have ports: pc  out  48  fetched instruction address; instr  out  32  fetched instruction; trap_if  out  1  fetch fault for this entry.

Function
REQ-009 SHALL keep next-fetch pointer fpc; fpc += 4 on each grant, wrapping modulo 2^48.
REQ-010 SHALL hold imem_req high with imem_addr = fpc stable until the cycle imem_gnt=1; no request change while waiting.
REQ-011 SHALL allow at most one outstanding request (granted, response not received); response arrives ≥1 cycle after grant.
REQ-012 SHALL buffer responses in a 2-entry FIFO of {pc, instr, trap}; issue only when fifo_count + outstanding < 2.
REQ-013 SHALL write FIFO at the edge where imem_rvalid=1; output register loads FIFO head at a later edge when valid_if=0 or stall_dec=0 (minimum 1 cycle rvalid→valid_if).
REQ-014 SHALL hold pc, instr, trap_if, valid_if unchanged while valid_if=1 and stall_dec=1.
REQ-015 SHALL clear valid_if when stall_dec=0 and FIFO empty.
REQ-016 SHALL implement FSM: FETCH (issue/await grant), WAIT (outstanding, no new issue possible), DRAIN (discard one stale response), HALT (after trap, no issue).
REQ-017 SHALL on redirect_valid=1 (highest priority): flush FIFO, clear valid_if next edge, set fpc=redirect_pc, drop any ungranted request.
REQ-018 SHALL on redirect with a request outstanding go to DRAIN; the next response is discarded, then FETCH.
REQ-019 SHALL on redirect in same cycle as imem_rvalid discard that response and go directly to FETCH.
REQ-020 SHALL on redirect in DRAIN update fpc and remain in DRAIN until stale response arrives.
REQ-021 SHALL on redirect_pc[1:0]≠0 issue no request, push {redirect_pc, NOP_INSTR, trap=1}, enter HALT.
REQ-022 SHALL on imem_err=1 push {addr, NOP_INSTR, trap=1} and enter HALT; only redirect leaves HALT.
REQ-023 SHALL deliver entries in fetch order; no loss or duplication except flushes in REQ-017..019.

Reset
REQ-024 SHALL on n_reset=0 asynchronously set: fpc=RESET_PC, FSM=FETCH, FIFO empty, outstanding=0, imem_req=0, imem_addr=0, valid_if=0, pc=0, instr=0, trap_if=0.
REQ-025 SHALL ignore any response to a request outstanding at reset assertion (memory reset together).
REQ-026 SHALL assert imem_req no earlier than first clk edge after n_reset deasserts.

Structure
REQ-027 SHALL place fetch-entry struct {pc, instr, trap}, FSM enum, NOP constant, address width 48 in shared package riscv_pkg.
REQ-028 SHALL implement the FIFO as sub-module fetch_fifo (depth 2, flush input, count output).

Verification
REQ-029 Reset, gnt=1 always, rvalid 1 cycle after gnt, stall_dec=0 -> pc sequence 0,4,8,12 with valid_if continuous after fill.
REQ-030 stall_dec=1 for 5 cycles mid-stream -> outputs frozen, max 1 outstanding, FIFO ≤2, no entry lost; resumes pc+4.
REQ-031 redirect_pc=48'h1000 while request outstanding -> stale response discarded, next valid pc=48'h1000, instr from 0x1000.
REQ-032 redirect_pc=48'h2002 -> no imem_req, valid_if with pc=48'h2002, instr=32'h00000013, trap_if=1; HALT until redirect.
REQ-033 imem_err=1 on fetch of 48'h8 -> pc=48'h8, trap_if=1, no further requests until redirect_pc=48'h0.
REQ-034 n_reset low mid-WAIT then high -> all outputs zero, first request at RESET_PC, stale rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: address width, NOP encoding, FIFO entry and fetch FSM states.
package riscv_pkg;

   localparam int unsigned ADDR_W   = 48;
   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
      logic              trap;
   } fetch_entry_t;

   typedef enum logic [1:0] {StFetch, StWait, StDrain, StHalt} fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch entries with synchronous flush; a push in the flush cycle survives.
module fetch_fifo
   import riscv_pkg::*;
(
   input  logic         clk,
   input  logic         n_reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   output fetch_entry_t rdata,
   output logic [1:0]   count
);

   fetch_entry_t mem_q [2];
   logic         wr_ptr_q, rd_ptr_q;
   logic [1:0]   count_q;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= push;
         count_q  <= {1'b0, push};
         if (push) mem_q[0] <= wdata;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/stage1.sv
// Instruction fetch stage: single-outstanding memory requests, 2-entry response buffer,
// registered output to decode, redirect flush and trap halt.
module stage1
   import riscv_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = NOP_WORD
) (
   input  logic              clk,
   input  logic              n_reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_err,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall_dec,
   output logic              valid_if,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr,
   output logic              trap_if
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d, oaddr_q, oaddr_d;
   logic              run_q;
   logic              valid_q, valid_d;
   fetch_entry_t      out_q, out_d;

   fetch_entry_t      push_entry, head;
   logic              push, pop, push_wait, outstanding, load, issue;
   logic [1:0]        count;
   logic [2:0]        credit;

   assign outstanding = (state_q == StWait) || (state_q == StDrain);
   assign push_wait   = (state_q == StWait) && imem_rvalid && !redirect_valid;
   assign load        = !valid_q || !stall_dec;
   assign pop         = load && (count != 2'd0) && !redirect_valid;

   // Slots committed after this edge: buffered entries plus a response still in flight.
   assign credit = {1'b0, count} + {2'b0, push_wait} - {2'b0, pop}
                 + {2'b0, outstanding && !imem_rvalid};

   // A new request may go out in the same cycle the previous response returns.
   assign issue = run_q && !redirect_valid && (credit < 3'd2) &&
                  ((state_q == StFetch) || ((state_q == StWait) && imem_rvalid && !imem_err));

   assign imem_req  = issue;
   assign imem_addr = issue ? fpc_q : '0;

   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      oaddr_d    = oaddr_q;
      push       = 1'b0;
      push_entry = '{pc: oaddr_q, instr: imem_rdata, trap: 1'b0};
      if (redirect_valid) begin
         fpc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            push       = 1'b1;
            push_entry = '{pc: redirect_pc, instr: NOP_INSTR, trap: 1'b1};
            state_d    = StHalt;
         end else if (outstanding && !imem_rvalid) begin
            state_d = StDrain;
         end else begin
            state_d = StFetch;
         end
      end else begin
         unique case (state_q)
            StFetch: ;
            StWait: begin
               if (imem_rvalid) begin
                  push = 1'b1;
                  if (imem_err) begin
                     push_entry.instr = NOP_INSTR;
                     push_entry.trap  = 1'b1;
                     state_d          = StHalt;
                  end else begin
                     state_d = StFetch;
                  end
               end
            end
            StDrain: if (imem_rvalid) state_d = StFetch;
            StHalt: ;
            default: state_d = StFetch;
         endcase
         if (issue && imem_gnt) begin
            fpc_d   = fpc_q + ADDR_W'(4);
            oaddr_d = fpc_q;
            state_d = StWait;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      out_d   = out_q;
      if (redirect_valid) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = (count != 2'd0);
         if (count != 2'd0) out_d = head;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= StFetch;
         fpc_q   <= RESET_PC;
         oaddr_q <= '0;
         run_q   <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         oaddr_q <= oaddr_d;
         run_q   <= 1'b1;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   fetch_fifo u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .flush   (redirect_valid),
      .push    (push),
      .wdata   (push_entry),
      .pop     (pop),
      .rdata   (head),
      .count   (count)
   );

   assign valid_if = valid_q;
   assign pc       = out_q.pc;
   assign instr    = out_q.instr;
   assign trap_if  = out_q.trap;

endmodule

// File: tb/tb_stage1.sv
// Bench for stage1: behavioural memory with random grant/latency and an in-order pc scoreboard.
module tb_stage1;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        imem_req, imem_gnt, imem_rvalid, imem_err;
   logic [47:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid, stall_dec;
   logic [47:0] redirect_pc;
   logic        valid_if, trap_if;
   logic [47:0] pc;
   logic [31:0] instr;

   always #5 clk = ~clk;

   stage1 #(.RESET_PC(48'h0), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .imem_err       (imem_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_dec      (stall_dec),
      .valid_if       (valid_if),
      .pc             (pc),
      .instr          (instr),
      .trap_if        (trap_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // memory model
   logic        mem_pend = 1'b0;
   int          mem_cnt  = 0;
   logic [47:0] mem_addr = '0;
   logic [47:0] err_addr = '1;
   int          lat_max  = 1;
   logic        gnt_rand = 1'b0;
   logic        spurious = 1'b0;

   // scoreboard
   logic [47:0] exp_pc = '0;
   logic        halted = 1'b0;
   int          n_consumed = 0;
   logic [47:0] last_pc = '0;
   logic [31:0] last_instr = '0;
   logic        last_trap = 1'b0;
   logic        cont = 1'b0;
   int          gaps = 0;
   logic        prev_wait = 1'b0, prev_hold = 1'b0;
   logic [47:0] prev_addr = '0;
   logic [81:0] prev_out = '0;

   function automatic logic [31:0] mem_word(input logic [47:0] a);
      return a[31:0] ^ {a[17:2], 16'hC0DE};
   endfunction

   task automatic chk(input string tag, input logic [81:0] got, input logic [81:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic cycle();
      logic        rv, want_trap, s_req, s_gnt;
      logic [47:0] s_addr;
      rv          = mem_pend && (mem_cnt == 0);
      imem_rvalid = rv || spurious;
      imem_rdata  = rv ? mem_word(mem_addr) : 32'hBAD0_BAD0;
      imem_err    = rv && (mem_addr == err_addr);
      #1;
      imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      s_req  = imem_req;
      s_gnt  = imem_gnt;
      s_addr = imem_addr;
      if (s_req) chk("addr_aligned", s_addr[1:0], 2'b00);
      if (s_req && s_gnt) chk("one_outstanding", mem_pend && !rv, 1'b0);
      if (prev_wait && !redirect_valid) chk("req_hold", {s_req, s_addr}, {1'b1, prev_addr});
      if (prev_hold) chk("stall_freeze", {valid_if, pc, instr, trap_if}, prev_out);
      if (halted && !redirect_valid) chk("halt_no_req", s_req, 1'b0);
      if (cont && !valid_if) gaps++;
      if (valid_if && !stall_dec && !redirect_valid) begin
         chk("entry_after_halt", halted, 1'b0);
         want_trap = (exp_pc[1:0] != 2'b00) || (exp_pc == err_addr);
         chk("pc", pc, exp_pc);
         chk("instr", instr, want_trap ? NOP : mem_word(exp_pc));
         chk("trap", trap_if, want_trap);
         last_pc    = pc;
         last_instr = instr;
         last_trap  = trap_if;
         n_consumed++;
         exp_pc = exp_pc + 48'd4;
         if (want_trap) halted = 1'b1;
      end
      if (redirect_valid) begin
         exp_pc = redirect_pc;
         halted = 1'b0;
      end
      prev_wait = s_req && !s_gnt && !redirect_valid;
      prev_addr = s_addr;
      prev_hold = valid_if && stall_dec && !redirect_valid;
      prev_out  = {valid_if, pc, instr, trap_if};
      @(posedge clk);
      if (rv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (s_req && s_gnt) begin
         mem_pend = 1'b1;
         mem_addr = s_addr;
         mem_cnt  = $urandom_range(1, lat_max) - 1;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_consumed(input int target, input int budget, input string tag);
      int k = 0;
      while (n_consumed < target && k < budget) begin
         cycle();
         k++;
      end
      chk(tag, n_consumed >= target, 1'b1);
   endtask

   task automatic wait_outstanding(input string tag);
      int k = 0;
      while (!(mem_pend && mem_cnt > 0) && k < 30) begin
         cycle();
         k++;
      end
      chk(tag, mem_pend && mem_cnt > 0, 1'b1);
   endtask

   task automatic do_redirect(input logic [47:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cycle();
      redirect_valid = 1'b0;
   endtask

   initial begin
      int k;
      n_reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; stall_dec = 1'b0;
      #3;
      chk("rst_outputs", {imem_req, imem_addr, valid_if, pc, instr, trap_if}, '0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      #1 chk("rst_no_early_req", imem_req, 1'b0);

      // Back-to-back stream, grant always, one-cycle latency.
      k = 0;
      while (!valid_if && k < 20) begin cycle(); k++; end
      chk("first_valid", valid_if, 1'b1);
      cont = 1'b1;
      run(8);
      cont = 1'b0;
      chk("continuous_gaps", gaps, 0);
      chk("stream_count", n_consumed >= 4, 1'b1);

      // Decode stall mid-stream.
      stall_dec = 1'b1;
      run(5);
      chk("stall_valid_held", valid_if, 1'b1);
      stall_dec = 1'b0;
      wait_consumed(n_consumed + 4, 40, "resume_after_stall");

      // Random grant, latency and stall.
      gnt_rand = 1'b1;
      lat_max  = 3;
      k = n_consumed;
      for (int i = 0; i < 300; i++) begin
         stall_dec = ($urandom_range(0, 3) == 0);
         cycle();
      end
      stall_dec = 1'b0;
      chk("random_progress", n_consumed >= k + 30, 1'b1);

      // Redirect with a request outstanding.
      gnt_rand = 1'b0;
      wait_outstanding("outstanding_for_redirect");
      do_redirect(48'h1000);
      wait_consumed(n_consumed + 1, 40, "redirect_progress");
      chk("redirect_pc", {last_trap, last_pc, last_instr}, {1'b0, 48'h1000, mem_word(48'h1000)});
      wait_consumed(n_consumed + 3, 40, "redirect_stream");

      // Misaligned redirect produces a trap entry and halts.
      do_redirect(48'h2002);
      wait_consumed(n_consumed + 1, 40, "misalign_progress");
      chk("misalign_entry", {last_trap, last_pc, last_instr}, {1'b1, 48'h2002, NOP});
      run(10);
      chk("misalign_halt_valid", valid_if, 1'b0);

      // Access fault on the fetch of 0x8.
      err_addr = 48'h8;
      do_redirect(48'h0);
      wait_consumed(n_consumed + 3, 40, "err_progress");
      chk("err_entry", {last_trap, last_pc, last_instr}, {1'b1, 48'h8, NOP});
      run(10);
      chk("err_halt_req", imem_req, 1'b0);
      do_redirect(48'h40);
      err_addr = '1;
      wait_consumed(n_consumed + 4, 40, "leave_halt");

      // Reset while a request is outstanding.
      lat_max = 3;
      wait_outstanding("outstanding_for_reset");
      #2 n_reset = 1'b0;
      #1 chk("midrst_outputs", {imem_req, imem_addr, valid_if, pc, instr, trap_if}, '0);
      mem_pend = 1'b0;
      imem_rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_reset   = 1'b1;
      prev_wait = 1'b0;
      prev_hold = 1'b0;
      exp_pc    = '0;
      halted    = 1'b0;
      spurious  = 1'b1;
      #1 chk("midrst_no_early_req", imem_req, 1'b0);
      cycle();
      spurious = 1'b0;
      wait_consumed(n_consumed + 3, 40, "post_reset_stream");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
